// File: rtl/lcd_480_272_scan.sv
// Raster scan generator and registered pixel output stage for the 480x272 LCD panel.
// Optional colour-bar override is built only when LCD_TEST_PATTERN_EN is defined.
module lcd_480_272_scan #(
  parameter int CLK_DIV  = 3,
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 2
) (
  input  logic       clock,
  input  logic       reset,
  output logic [8:0] x,
  output logic [8:0] y,
  input  logic [4:0] red,
  input  logic [5:0] green,
  input  logic [4:0] blue,
  input  logic       test_pattern,
  output logic       lcd_clk,
  output logic       lcd_de,
  output logic       lcd_hsync,
  output logic       lcd_vsync,
  output logic [4:0] lcd_r,
  output logic [5:0] lcd_g,
  output logic [4:0] lcd_b,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic [9:0]       hcnt;
  logic [8:0]       vcnt;
  logic             pe;
  logic             h_last;
  logic             v_last;
  logic             h_act;
  logic             v_act;
  logic             h_sync_on;
  logic             v_sync_on;
  logic [4:0]       pix_r;
  logic [5:0]       pix_g;
  logic [4:0]       pix_b;

  assign pe        = (div == DIV_LAST);
  assign div_next  = pe ? '0 : div + 1'b1;
  assign h_last    = (hcnt == 10'(H_TOTAL - 1));
  assign v_last    = (vcnt == 9'(V_TOTAL - 1));
  assign h_act     = (hcnt < 10'(H_ACTIVE));
  assign v_act     = (vcnt < 9'(V_ACTIVE));
  assign h_sync_on = (hcnt >= 10'(H_ACTIVE + H_FP)) && (hcnt < 10'(H_ACTIVE + H_FP + H_SYNC));
  assign v_sync_on = (vcnt >= 9'(V_ACTIVE + V_FP)) && (vcnt < 9'(V_ACTIVE + V_FP + V_SYNC));

  assign x = (h_act && v_act) ? hcnt[8:0] : '0;
  assign y = v_act ? vcnt : '0;

`ifdef LCD_TEST_PATTERN_EN
  logic [9:0] bar_full;
  logic [2:0] bar;

  assign bar_full = hcnt / 10'd60;
  assign bar      = bar_full[2:0];

  always_comb begin
    pix_r = red;
    pix_g = green;
    pix_b = blue;
    if (test_pattern) begin
      pix_r = {5{bar[0]}};
      pix_g = {6{bar[1]}};
      pix_b = {5{bar[2]}};
    end
  end
`else
  logic unused_test_pattern;

  assign unused_test_pattern = test_pattern;

  always_comb begin
    pix_r = red;
    pix_g = green;
    pix_b = blue;
  end
`endif

  // lcd_clk is registered from the next divider value so it falls on the same edge as pe.
  always_ff @(posedge clock) begin
    if (reset) begin
      div         <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      lcd_clk     <= 1'b0;
      lcd_de      <= 1'b0;
      lcd_hsync   <= 1'b1;
      lcd_vsync   <= 1'b1;
      lcd_r       <= '0;
      lcd_g       <= '0;
      lcd_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_next;
      lcd_clk     <= (div_next >= DIV_HALF);
      frame_start <= pe && h_last && v_last;
      if (pe) begin
        hcnt <= h_last ? '0 : hcnt + 1'b1;
        if (h_last) begin
          vcnt <= v_last ? '0 : vcnt + 1'b1;
        end
        // Outputs use the pre-increment counters, giving one pixel of latency for all of them.
        lcd_de    <= h_act && v_act;
        lcd_hsync <= ~h_sync_on;
        lcd_vsync <= ~v_sync_on;
        lcd_r     <= (h_act && v_act) ? pix_r : '0;
        lcd_g     <= (h_act && v_act) ? pix_g : '0;
        lcd_b     <= (h_act && v_act) ? pix_b : '0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_480_272_scan.sv
// Self-checking bench for lcd_480_272_scan: default-size and shrunken-timing instances
// checked every clock against an arithmetic model of the raster, plus vector table and corner sequences.
module tb_lcd_480_272_scan;

  localparam int SD = 3, SHA = 8, SHFP = 2, SHS = 3, SHBP = 2;
  localparam int SVA = 6, SVFP = 1, SVS = 2, SVBP = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic test_pattern = 1'b0;
  logic [4:0] seed_r = '0;
  logic [5:0] seed_g = '0;
  logic [4:0] seed_b = '0;

  always #5 clock = ~clock;

  logic [8:0] fx, fy;
  logic [4:0] f_red, f_blue, f_r, f_b;
  logic [5:0] f_green, f_g;
  logic f_clk, f_de, f_hs, f_vs, f_fs;

  logic [8:0] sx, sy;
  logic [4:0] s_red, s_blue, s_r, s_b;
  logic [5:0] s_green, s_g;
  logic s_clk, s_de, s_hs, s_vs, s_fs;

  // The caller's colour is a pure function of (x, y), as hackathon_top-style logic would be.
  assign f_red   = fx[4:0] ^ seed_r;
  assign f_green = 6'(fx + {fy[7:0], 1'b0}) + seed_g;
  assign f_blue  = fy[4:0] ^ seed_b;
  assign s_red   = sx[4:0] ^ seed_r;
  assign s_green = 6'(sx + {sy[7:0], 1'b0}) + seed_g;
  assign s_blue  = sy[4:0] ^ seed_b;

  lcd_480_272_scan dut_full (
    .clock(clock), .reset(reset), .x(fx), .y(fy),
    .red(f_red), .green(f_green), .blue(f_blue), .test_pattern(test_pattern),
    .lcd_clk(f_clk), .lcd_de(f_de), .lcd_hsync(f_hs), .lcd_vsync(f_vs),
    .lcd_r(f_r), .lcd_g(f_g), .lcd_b(f_b), .frame_start(f_fs)
  );

  lcd_480_272_scan #(
    .CLK_DIV(SD), .H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP),
    .V_ACTIVE(SVA), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP)
  ) dut_small (
    .clock(clock), .reset(reset), .x(sx), .y(sy),
    .red(s_red), .green(s_green), .blue(s_blue), .test_pattern(test_pattern),
    .lcd_clk(s_clk), .lcd_de(s_de), .lcd_hsync(s_hs), .lcd_vsync(s_vs),
    .lcd_r(s_r), .lcd_g(s_g), .lcd_b(s_b), .frame_start(s_fs)
  );

  int n = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         clocks;
    logic [8:0] x;
    logic [8:0] y;
    logic       clk;
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [15:0] colour(input int h, input int v, input logic tp);
    int bar;
    bar = h / 60;
`ifdef LCD_TEST_PATTERN_EN
    if (tp) begin
      return {((bar & 1) != 0) ? 5'h1f : 5'h00,
              ((bar & 2) != 0) ? 6'h3f : 6'h00,
              ((bar & 4) != 0) ? 5'h1f : 5'h00};
    end
`endif
    return {5'(h) ^ seed_r, 6'(h + 2 * v) + seed_g, 5'(v) ^ seed_b};
  endfunction

  // Expected outputs after cnt clock edges since reset release, from raster arithmetic alone.
  function automatic logic [38:0] model(input int d, ha, hfp, hsw, hbp, va, vfp, vsw, vbp,
                                        input int cnt, input logic tp);
    int ht, vt, total, p, q, h, v, pq, ph, pv;
    logic [8:0] ex, ey;
    logic ck, de, hs, vs, fs;
    logic [15:0] rgb;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    total = ht * vt;
    p = cnt / d;
    q = p % total;
    h = q % ht;
    v = q / ht;
    ex = (h < ha && v < va) ? 9'(h) : 9'd0;
    ey = (v < va) ? 9'(v) : 9'd0;
    ck = (cnt % d) >= (d / 2);
    de = 1'b0; hs = 1'b1; vs = 1'b1; rgb = '0; fs = 1'b0;
    if (p > 0) begin
      pq = (p - 1) % total;
      ph = pq % ht;
      pv = pq / ht;
      de = (ph < ha) && (pv < va);
      hs = !(ph >= ha + hfp && ph < ha + hfp + hsw);
      vs = !(pv >= va + vfp && pv < va + vfp + vsw);
      if (de) rgb = colour(ph, pv, tp);
      fs = ((cnt % d) == 0) && (q == 0);
    end
    return {ex, ey, ck, de, hs, vs, rgb, fs};
  endfunction

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput();
    logic [38:0] exp_f, exp_s, act_f, act_s;
    exp_f = model(3, 480, 2, 41, 2, 272, 2, 10, 2, n, test_pattern);
    exp_s = model(SD, SHA, SHFP, SHS, SHBP, SVA, SVFP, SVS, SVBP, n, test_pattern);
    act_f = {fx, fy, f_clk, f_de, f_hs, f_vs, f_r, f_g, f_b, f_fs};
    act_s = {sx, sy, s_clk, s_de, s_hs, s_vs, s_r, s_g, s_b, s_fs};
    checks += 2;
    if (act_f !== exp_f) begin
      failures++;
      $display("[TB] FAIL full_model n=%0d actual=%h expected=%h", n, act_f, exp_f);
    end
    if (act_s !== exp_s) begin
      failures++;
      $display("[TB] FAIL small_model n=%0d actual=%h expected=%h", n, act_s, exp_s);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) n = 0;
    else n++;
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic rst, input logic tp);
    reset = rst;
    test_pattern = tp;
    if (rst) begin
      seed_r = 5'($urandom);
      seed_g = 6'($urandom);
      seed_b = 5'($urandom);
    end
  endtask

  task automatic waitFrameStart(output int at);
    at = -1;
    for (int k = 0; k < 600 && at < 0; k++) begin
      tick();
      if (s_fs) at = n;
    end
  endtask

  initial begin
    int de_cnt, hs_cnt, first_fs, second_fs;

    vecs[0]  = '{0,   9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1,   9'd0, 9'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{3,   9'd1, 9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{24,  9'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{30,  9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{33,  9'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{39,  9'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{42,  9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{48,  9'd1, 9'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{318, 9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{450, 9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{451, 9'd0, 9'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{453, 9'd1, 9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    $display("[TB] reset hold of 5 clocks");
    applyStimulus(1'b1, 1'b0);
    repeat (5) tick();

    $display("[TB] vector table on small timing");
    for (int i = 0; i < 13; i++) begin
      logic [14:0] act, exp;
      applyStimulus(1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0);
      repeat (vecs[i].clocks) tick();
      act = {sx, sy, s_clk, s_de, s_hs, s_vs, s_fs};
      exp = {vecs[i].x, vecs[i].y, vecs[i].clk, vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].fs};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("[TB] FAIL vector%0d: actual=%h expected=%h", i, act, exp);
      end
    end

    $display("[TB] one full-size line: de and hsync widths");
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    de_cnt = 0;
    hs_cnt = 0;
    repeat (1575) begin
      tick();
      if (f_de) de_cnt++;
      if (!f_hs) hs_cnt++;
    end
    checkValue("line_de_clocks", de_cnt, 1440);
    checkValue("line_hsync_low_clocks", hs_cnt, 123);

    $display("[TB] frame_start spacing on small timing");
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    waitFrameStart(first_fs);
    checkValue("first_frame_start", first_fs, 450);
    waitFrameStart(second_fs);
    checkValue("frame_spacing", second_fs - first_fs, 450);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    repeat (150) tick();
    checkValue("mid_frame_position", {sx, sy}, {9'd5, 9'd3});
    applyStimulus(1'b1, 1'b0);
    tick();
    checkValue("reset_xy_syncs", {sx, sy, s_hs, s_vs}, {9'd0, 9'd0, 1'b1, 1'b1});
    applyStimulus(1'b0, 1'b0);
    waitFrameStart(first_fs);
    checkValue("frame_start_after_reset", first_fs, 450);

    $display("[TB] randomized phases");
    for (int i = 0; i < 8; i++) begin
      logic tp;
      tp = 1'($urandom);
      applyStimulus(1'b1, tp);
      repeat ($urandom_range(1, 5)) tick();
      applyStimulus(1'b0, tp);
      repeat ($urandom_range(100, 3000)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
